// File: rtl/issue_queue_pkg.sv
// Shared types for the decode-to-issue queue: field widths, entry layout, NOP opcode.
package sparc_pkg;
  localparam int REG_W = 5;
  localparam int OP_W  = 6;

  localparam logic [OP_W-1:0] OPTYPE_NOP = 6'b000000;

  typedef struct packed {
    logic [REG_W-1:0] reg_1;
    logic [REG_W-1:0] reg_2;
    logic [REG_W-1:0] reg_3;
    logic [OP_W-1:0]  operator_type;
  } iq_entry_t;
endpackage

// File: rtl/issue_queue_if.sv
// Decode-side push and issue-side pop handshakes for issue_queue, plus flush and occupancy.
interface issue_queue_if #(parameter int DEPTH = 4);
  import sparc_pkg::*;

  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [REG_W-1:0]       in_reg_1;
  logic [REG_W-1:0]       in_reg_2;
  logic [REG_W-1:0]       in_reg_3;
  logic [OP_W-1:0]        in_operator_type;
  logic                   out_valid;
  logic                   out_ready;
  logic [REG_W-1:0]       out_reg_1;
  logic [REG_W-1:0]       out_reg_2;
  logic [REG_W-1:0]       out_reg_3;
  logic [OP_W-1:0]        out_operator_type;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output flush, in_valid, in_reg_1, in_reg_2, in_reg_3, in_operator_type, out_ready,
    input  in_ready, out_valid, out_reg_1, out_reg_2, out_reg_3, out_operator_type, count
  );

  modport slave (
    input  flush, in_valid, in_reg_1, in_reg_2, in_reg_3, in_operator_type, out_ready,
    output in_ready, out_valid, out_reg_1, out_reg_2, out_reg_3, out_operator_type, count
  );
endinterface

// File: rtl/issue_queue_storage.sv
// iq_storage: DEPTH-entry register file, one write port, asynchronous read, cleared on reset.
module iq_storage
  import sparc_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  iq_entry_t     wdata,
  input  logic [PW-1:0] raddr,
  output iq_entry_t     rdata
);
  iq_entry_t mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk or posedge reset) begin
      if (reset)                           mem[i] <= '0;
      else if (we && waddr == PW'(i))      mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/issue_queue.sv
// In-order circular issue queue between decode and the Tomasulo allocator.
// Define ISSUE_QUEUE_BYPASS_EN to let an empty queue pass input straight to output.
module issue_queue
  import sparc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          reset,
  issue_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic          empty, push, pop, byp;
  iq_entry_t     in_ent, head;

  assign in_ent = '{reg_1: q.in_reg_1, reg_2: q.in_reg_2, reg_3: q.in_reg_3,
                    operator_type: q.in_operator_type};

  assign empty      = (cnt == '0);
  // Ready depends only on registered occupancy, so a pop never frees a slot same-cycle.
  assign q.in_ready = (cnt != CW'(DEPTH));
  assign q.count    = cnt;

`ifdef ISSUE_QUEUE_BYPASS_EN
  assign byp         = empty && q.in_valid && q.out_ready && !q.flush;
  assign q.out_valid = empty ? q.in_valid : 1'b1;
  iq_entry_t out_ent;
  assign out_ent     = (empty && q.in_valid) ? in_ent : head;
`else
  assign byp         = 1'b0;
  assign q.out_valid = !empty;
  iq_entry_t out_ent;
  assign out_ent     = head;
`endif

  assign q.out_reg_1         = out_ent.reg_1;
  assign q.out_reg_2         = out_ent.reg_2;
  assign q.out_reg_3         = out_ent.reg_3;
  assign q.out_operator_type = out_ent.operator_type;

  // A bypassed instruction is consumed without touching pointers or storage.
  assign push = q.in_valid && q.in_ready && !byp && !q.flush;
  assign pop  = !empty && q.out_ready && !q.flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end

  iq_storage #(.DEPTH(DEPTH)) u_store (
    .clk   (clk),
    .reset (reset),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_ent),
    .raddr (rd_ptr),
    .rdata (head)
  );
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Receive-side buffer between the decode stage and the Tomasulo issue logic.
- Accepts decoded instructions (three register specifiers plus operator type) with a valid/ready handshake and holds them in order in a circular FIFO.
- Presents the head entry to the reservation-station allocator with its own valid/ready handshake.
- Backpressures decode/fetch when full; supports a pipeline flush.

Parameters:
- DEPTH, 4, number of entries; power of two, at least 2.
- REG_W, 5, register specifier width.
- OP_W, 6, operator type width.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  decode presents an instruction.
- in_ready  output  1  queue can accept this cycle.
- in_reg_1  input  REG_W  destination register.
- in_reg_2  input  REG_W  source register 1.
- in_reg_3  input  REG_W  source register 2.
- in_operator_type  input  OP_W  decoded operation.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  Tomasulo accepts the head entry.
- out_reg_1  output  REG_W  head entry, destination register.
- out_reg_2  output  REG_W  head entry, source register 1.
- out_reg_3  output  REG_W  head entry, source register 2.
- out_operator_type  output  OP_W  head entry operator type.
- count  output  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (asynchronous, active-high, any time, including mid-transfer):
  - wr_ptr, rd_ptr and count go to 0.
  - All storage entries are cleared to 0.
  - out_valid=0, all out_* fields=0, in_ready=1 once reset deasserts.
- Push occurs when in_valid && in_ready. The entry is written at wr_ptr, then wr_ptr increments modulo DEPTH.
- Pop occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- in_ready = (count < DEPTH). It depends only on registered state; there is no same-cycle push-when-full even if a pop occurs.
- out_valid = (count != 0). out_* fields are driven directly from the entry at rd_ptr.
- Latency: an entry pushed in cycle N appears at the outputs with out_valid=1 in cycle N+1 (queue previously empty).
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Full (count==DEPTH): in_ready=0; in_valid is ignored and no entry is overwritten.
- Empty: out_valid=0; out_ready is ignored and no underflow occurs. out_* fields hold stale data that must not be used.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. count alone distinguishes full from empty.
- Flush (synchronous):
  - Next cycle: count=0, wr_ptr=rd_ptr=0, out_valid=0.
  - Flush has priority over any push or pop in the same cycle; that push is dropped.
  - Storage contents are not cleared.
- Order is strictly FIFO. Instruction fields are never modified.

Optional Feature:
- ISSUE_QUEUE_BYPASS_EN defined:
  - When the queue is empty and in_valid && out_ready && !flush, the input passes combinationally to out_* with out_valid=1 in the same cycle.
  - The instruction is consumed without being written. count and pointers are unchanged.
  - When empty, out_valid = in_valid.
- ISSUE_QUEUE_BYPASS_EN not defined: minimum latency is 1 cycle as above, and there is no combinational path from in_* to out_*.

Decomposition:
- sparc_pkg holds:
  - REG_W and OP_W constants.
  - The iq_entry_t struct (reg_1, reg_2, reg_3, operator_type).
  - OPTYPE_NOP = 6'b000000.
- One sub-module, iq_storage: a DEPTH x iq_entry_t register array with a write port (we, waddr, wdata) and an asynchronous read port (raddr, rdata), reset to 0.
- Pointer, count and handshake logic stay in issue_queue.

Test Plan:
- Reset then single push of {1,2,3,op=6'h02} in cycle 0 -> cycle 1: out_valid=1, out_reg_1=1, out_reg_2=2, out_reg_3=3, count=1. Pop in cycle 1 -> cycle 2: out_valid=0, count=0.
- Fill test, DEPTH=4: push 4 entries with out_ready=0 -> count=4, in_ready=0. 5th push is not accepted. Then drain -> entries come out in FIFO order and the 5th entry is never seen.
- Wrap test: push and pop continuously for 10 entries with alternating out_ready -> all 10 emerge in order; pointers wrap twice; count never exceeds 4.
- Simultaneous push/pop at count=2 -> count stays 2; the new entry emerges after the two older entries.
- Flush with count=3 and in_valid=1 -> next cycle count=0, out_valid=0. The flushed-cycle input is not stored; a subsequent push emerges first.
- Async reset asserted mid-cycle with count=2 -> out_valid drops immediately without a clock edge; after release count=0 and in_ready=1.
- With ISSUE_QUEUE_BYPASS_EN, empty queue, in_valid=1, out_ready=1, fields {7,8,9} -> same cycle out_valid=1, out_reg_1=7; count stays 0.
